psum_writeback: RTL and testbench
=================================

PSUM_WRITEBACK -- requirements
Module: psum_writeback

Interface
REQ-001 The block SHALL take these parameters:
- col, default 8, MAC columns per psum vector.
- psum_bw, default 16, bits per psum lane.
- row, default 8, vectors per tile.
- addr_w, default 11, psum SRAM address width.

REQ-002 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  pulse; begins writeback of one tile.
- base_addr  in  addr_w  SRAM address of vector 0; sampled when start is accepted.
- ofifo_valid  in  1  the OFIFO holds at least one complete psum vector.
- ofifo_output  in  col*psum_bw  OFIFO head vector; valid in any cycle with ofifo_valid=1.
- ofifo_rd  out  1  pops the OFIFO head at the rising edge; drives the corelet inst[6].
- sram_cen  out  1  psum SRAM chip enable, active-low.
- sram_wen  out  1  psum SRAM write enable, active-low.
- sram_addr  out  addr_w  psum SRAM address.
- sram_din  out  col*psum_bw  psum SRAM write data.
- busy  out  1  high from start acceptance until the psum_ready cycle, inclusive.
- psum_ready  out  1  one-cycle pulse: the tile is fully written; drives the corelet psum_ready.
- start_err  out  1  sticky; set when start arrives while busy.

Function
REQ-003 The FSM SHALL have exactly four states, IDLE, DRAIN, FLUSH and DONE, and SHALL be reset to IDLE.

REQ-004 In IDLE, start=1 SHALL latch base_addr, clear the vector counter (width clog2(row)+1) and move to DRAIN.

REQ-005 In DRAIN, ofifo_rd SHALL equal ofifo_valid, and ofifo_rd SHALL never assert outside DRAIN.

REQ-006 Every read cycle (ofifo_rd=1) SHALL register ofifo_output into sram_din, and in the next cycle SHALL present a write: sram_cen=0, sram_wen=0, sram_addr = latched base + count, with count incremented after each write.
- Read-to-write latency is exactly 1 cycle.
- Back-to-back reads SHALL give one write per cycle.

REQ-007 When ofifo_valid=0 in DRAIN, the block SHALL stall with no pop, hold count, and keep sram_cen=1 in the following cycle (no write issued).

REQ-008 The read that pops vector row-1 SHALL move the FSM to FLUSH; FLUSH SHALL issue that final write and move to DONE.

REQ-009 DONE SHALL assert psum_ready=1 for exactly one cycle and return to IDLE.
- busy SHALL drop in the cycle after DONE.
- start is accepted again from that cycle.

REQ-010 Address arithmetic SHALL be modulo 2^addr_w, so base_addr = 2^addr_w-2 with row=8 wraps to 0.

REQ-011 start while busy SHALL be ignored (no restart, no change to the latched address) and SHALL set start_err, which clears only on reset.

REQ-012 When not writing, sram_cen=1, sram_wen=1, and sram_addr and sram_din hold their last values.

REQ-013 Exactly row pops and row writes SHALL occur per accepted start; a surplus ofifo_valid after the last pop SHALL NOT be read.

Reset
REQ-014 Asserting reset at any time, including mid-tile, SHALL immediately set:
- state=IDLE, count=0;
- ofifo_rd=0, sram_cen=1, sram_wen=1;
- sram_addr=0, sram_din=0;
- busy=0, psum_ready=0, start_err=0.
A partially written tile SHALL NOT produce psum_ready.

REQ-015 After reset deasserts, the block SHALL act on no start until the first rising edge at which start=1.

Structure
REQ-016 The FSM state encoding, the default parameter values and the active-low SRAM control constants SHALL live in the shared core package, for reuse by the core-level SRAM arbiter.

REQ-017 The block SHALL be a single flat module with no sub-module; the 1-cycle data register and the address counter are inline.

Verification
REQ-018 Streaming: base_addr=0x040, ofifo_valid held 1, start pulse → writes to 0x040..0x047 on 8 consecutive cycles; sram_din equals the pushed vectors in order; psum_ready pulses 2 cycles after the last pop.

REQ-019 Bubbles: ofifo_valid toggles 1,0,1,0… → 8 writes total, none in the cycle after a 0-valid cycle; addresses stay contiguous; exactly one psum_ready.

REQ-020 Wrap: addr_w=11, base_addr=0x7FE → addresses 0x7FE, 0x7FF, 0x000..0x005.

REQ-021 Start while busy: second start at vector 3 → ignored, start_err=1, addresses unchanged, only one psum_ready.

REQ-022 Reset mid-tile: reset asserted after 4 writes → all outputs at reset values asynchronously; no psum_ready; a new start with base 0x100 writes 0x100..0x107.

REQ-023 Surplus data: the OFIFO holds 10 vectors → exactly 8 pops; ofifo_valid remains 1 afterwards.

Source files
------------

// File: rtl/psum_writeback_pkg.sv
// -----------------------------------------------------------------------------
// psum_writeback_pkg
//
// Shared core package for the psum writeback path. It holds:
//   - the default geometry of a psum tile (MAC columns, lane width, vectors
//     per tile, psum SRAM address width);
//   - the writeback FSM state encoding;
//   - the active-low psum SRAM control levels.
// The core-level SRAM arbiter imports the same package so that it decodes
// the writeback state and SRAM strobes with identical constants.
// -----------------------------------------------------------------------------
package psum_writeback_pkg;

  // Default tile geometry.
  localparam int COL_DEF     = 8;   // MAC columns per psum vector
  localparam int PSUM_BW_DEF = 16;  // bits per psum lane
  localparam int ROW_DEF     = 8;   // vectors per tile
  localparam int ADDR_W_DEF  = 11;  // psum SRAM address width

  // Writeback FSM states.
  //   IDLE  : waiting for start
  //   DRAIN : popping OFIFO vectors, one write follows each pop
  //   FLUSH : the write of the final vector is on the SRAM port
  //   DONE  : psum_ready pulse
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } wb_state_e;

  // Psum SRAM control levels (both strobes are active-low).
  localparam logic SRAM_CEN_ON    = 1'b0;  // chip selected
  localparam logic SRAM_CEN_OFF   = 1'b1;  // chip deselected
  localparam logic SRAM_WEN_WRITE = 1'b0;  // write cycle
  localparam logic SRAM_WEN_IDLE  = 1'b1;  // no write

endpackage : psum_writeback_pkg

// File: rtl/psum_writeback.sv
// -----------------------------------------------------------------------------
// psum_writeback
//
// Drains one tile of partial-sum vectors from the OFIFO into the psum SRAM.
// A start pulse latches the SRAM base address; the block then pops exactly
// `row` vectors from the OFIFO (one per cycle whenever the OFIFO has data) and
// writes each one, one cycle after its pop, to base + vector index (modulo
// 2^addr_w). When the last write has been issued a one-cycle psum_ready pulse
// tells the corelet that the tile is in SRAM.
//
// Ports
//   clk           in   clock, all state on the rising edge
//   reset         in   asynchronous active-high reset
//   start         in   pulse, begins writeback of one tile
//   base_addr     in   SRAM address of vector 0, sampled on start acceptance
//   ofifo_valid   in   OFIFO holds at least one complete psum vector
//   ofifo_output  in   OFIFO head vector (col*psum_bw bits)
//   ofifo_rd      out  pops the OFIFO head at the rising edge
//   sram_cen      out  psum SRAM chip enable, active-low
//   sram_wen      out  psum SRAM write enable, active-low
//   sram_addr     out  psum SRAM address
//   sram_din      out  psum SRAM write data
//   busy          out  high from start acceptance through the psum_ready cycle
//   psum_ready    out  one-cycle pulse, tile fully written
//   start_err     out  sticky, start seen while busy (cleared by reset only)
// -----------------------------------------------------------------------------
module psum_writeback
  import psum_writeback_pkg::*;
#(
  parameter int col     = COL_DEF,
  parameter int psum_bw = PSUM_BW_DEF,
  parameter int row     = ROW_DEF,
  parameter int addr_w  = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [addr_w-1:0]        base_addr,
  input  logic                     ofifo_valid,
  input  logic [col*psum_bw-1:0]   ofifo_output,
  output logic                     ofifo_rd,
  output logic                     sram_cen,
  output logic                     sram_wen,
  output logic [addr_w-1:0]        sram_addr,
  output logic [col*psum_bw-1:0]   sram_din,
  output logic                     busy,
  output logic                     psum_ready,
  output logic                     start_err
);

  localparam int cnt_w  = $clog2(row) + 1;
  localparam int data_w = col * psum_bw;

  // Index of the final vector of a tile.
  localparam logic [cnt_w-1:0] last_idx = cnt_w'(row - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  wb_state_e            state_q,     state_d;
  logic [cnt_w-1:0]     count_q,     count_d;      // vectors popped so far
  logic [addr_w-1:0]    base_q,      base_d;       // latched tile base address
  logic                 sram_cen_q,  sram_cen_d;
  logic                 sram_wen_q,  sram_wen_d;
  logic [addr_w-1:0]    sram_addr_q, sram_addr_d;
  logic [data_w-1:0]    sram_din_q,  sram_din_d;
  logic                 start_err_q, start_err_d;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  // The SRAM port is fully registered: a pop in cycle N loads the vector,
  // address and strobes into the output flops, so the write appears on the
  // SRAM pins in cycle N+1. Counting pops (rather than completed writes)
  // lets the address of the pending write be formed from count_q directly,
  // and lets the final pop be recognised in the same cycle it happens.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    base_d      = base_q;
    sram_cen_d  = SRAM_CEN_OFF;
    sram_wen_d  = SRAM_WEN_IDLE;
    sram_addr_d = sram_addr_q;   // address and data hold between writes
    sram_din_d  = sram_din_q;
    start_err_d = start_err_q;
    ofifo_rd    = 1'b0;
    psum_ready  = 1'b0;
    busy        = (state_q != IDLE);

    // A start outside IDLE is dropped, but remembered until reset.
    if (start && (state_q != IDLE)) begin
      start_err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          count_d = '0;
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        // Pop whenever the OFIFO has a vector; no pop means no write next cycle.
        ofifo_rd = ofifo_valid;
        if (ofifo_valid) begin
          sram_din_d  = ofifo_output;
          sram_addr_d = base_q + addr_w'(count_q);   // wraps modulo 2^addr_w
          sram_cen_d  = SRAM_CEN_ON;
          sram_wen_d  = SRAM_WEN_WRITE;
          count_d     = count_q + 1'b1;
          // Stop popping after the last vector so surplus OFIFO data stays put.
          if (count_q == last_idx) begin
            state_d = FLUSH;
          end
        end
      end

      FLUSH: begin
        // The final write is on the SRAM port this cycle.
        state_d = DONE;
      end

      DONE: begin
        psum_ready = 1'b1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: counter, latched base, SRAM port, error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      base_q      <= '0;
      sram_cen_q  <= SRAM_CEN_OFF;
      sram_wen_q  <= SRAM_WEN_IDLE;
      sram_addr_q <= '0;
      sram_din_q  <= '0;
      start_err_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      base_q      <= base_d;
      sram_cen_q  <= sram_cen_d;
      sram_wen_q  <= sram_wen_d;
      sram_addr_q <= sram_addr_d;
      sram_din_q  <= sram_din_d;
      start_err_q <= start_err_d;
    end
  end

  assign sram_cen  = sram_cen_q;
  assign sram_wen  = sram_wen_q;
  assign sram_addr = sram_addr_q;
  assign sram_din  = sram_din_q;
  assign start_err = start_err_q;

endmodule : psum_writeback

// File: tb/tb_psum_writeback.sv
// -----------------------------------------------------------------------------
// tb_psum_writeback
//
// Drives psum_writeback with directed tile scenarios followed by a long
// randomized run (random OFIFO fill, valid bubbles, starts, bases and
// asynchronous resets). A transaction-level model predicts, every cycle, the
// pop strobe, the SRAM write (address/data), busy, psum_ready and start_err;
// one compare process checks the DUT against it on every falling edge.
// Directed scenarios additionally pin absolute addresses and latencies.
// -----------------------------------------------------------------------------
module tb_psum_writeback;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int ROW = 8;
  localparam int AW  = 11;
  localparam int DW  = COL * BW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          ofifo_valid;
  logic [DW-1:0] ofifo_output;
  logic          ofifo_rd;
  logic          sram_cen;
  logic          sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic          busy;
  logic          psum_ready;
  logic          start_err;

  always #5 clk = ~clk;

  psum_writeback #(
    .col     (COL),
    .psum_bw (BW),
    .row     (ROW),
    .addr_w  (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .ofifo_valid  (ofifo_valid),
    .ofifo_output (ofifo_output),
    .ofifo_rd     (ofifo_rd),
    .sram_cen     (sram_cen),
    .sram_wen     (sram_wen),
    .sram_addr    (sram_addr),
    .sram_din     (sram_din),
    .busy         (busy),
    .psum_ready   (psum_ready),
    .start_err    (start_err)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DW-1:0] fifo[$];      // OFIFO contents, head at index 0
  bit            gate = 1'b0;  // valid gating to create bubbles
  bit            rd_s = 1'b0;  // DUT pop strobe sampled mid-cycle

  // Observation logs, written only by the monitor.
  int            w_cyc[$];
  logic [AW-1:0] w_addr[$];
  logic [DW-1:0] w_din[$];
  int            rdy_cyc[$];
  int            n_pops = 0;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model (transaction level)
  //   - a tile is open from start acceptance until its psum_ready cycle;
  //   - while open and fewer than ROW vectors popped, a pop happens exactly
  //     when the OFIFO shows valid;
  //   - each pop k produces a write one cycle later at (base + k) mod 2^AW
  //     carrying the popped vector;
  //   - psum_ready is the second cycle after the final pop; the tile closes
  //     after it.
  // ---------------------------------------------------------------------------
  bit            m_busy = 1'b0;
  int            m_pops = 0;
  int            m_base = 0;
  int            m_tail = 0;     // cycles elapsed since the final pop
  bit            m_wr   = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_din  = '0;
  bit            m_err  = 1'b0;

  function automatic bit m_rd_f();
    return m_busy && (m_pops < ROW) && ofifo_valid;
  endfunction

  function automatic bit m_ready_f();
    return m_busy && (m_pops == ROW) && (m_tail == 1);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_pops <= 0;
      m_base <= 0;
      m_tail <= 0;
      m_wr   <= 1'b0;
      m_addr <= '0;
      m_din  <= '0;
      m_err  <= 1'b0;
    end else begin
      m_wr <= m_rd_f();
      if (m_rd_f()) begin
        m_addr <= AW'((m_base + m_pops) % (1 << AW));
        m_din  <= ofifo_output;
        m_pops <= m_pops + 1;
        m_tail <= 0;
      end else if (m_busy && m_pops == ROW) begin
        m_tail <= m_tail + 1;
      end
      if (m_ready_f()) m_busy <= 1'b0;
      if (start && !m_busy) begin
        m_busy <= 1'b1;
        m_base <= int'(base_addr);
        m_pops <= 0;
        m_tail <= 0;
      end else if (start && m_busy) begin
        m_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process and monitor (falling edge, away from the active edge)
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    rd_s <= ofifo_rd;
    chk("busy",       busy,       m_busy);
    chk("ofifo_rd",   ofifo_rd,   m_rd_f());
    chk("psum_ready", psum_ready, m_ready_f());
    chk("start_err",  start_err,  m_err);
    chk("sram_cen",   sram_cen,   !m_wr);
    chk("sram_wen",   sram_wen,   !m_wr);
    chk("sram_addr",  sram_addr,  m_addr);
    chk("sram_din",   sram_din,   m_din);
    if (!sram_cen) begin
      w_cyc.push_back(cyc);
      w_addr.push_back(sram_addr);
      w_din.push_back(sram_din);
    end
    if (psum_ready) rdy_cyc.push_back(cyc);
    if (ofifo_rd) n_pops <= n_pops + 1;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive_fifo();
    ofifo_valid  = gate && (fifo.size() != 0);
    ofifo_output = (fifo.size() != 0) ? fifo[0] : '0;
  endtask

  // Advance one cycle; the OFIFO pops if the DUT strobed rd in that cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rd_s && fifo.size() != 0) void'(fifo.pop_front());
    drive_fifo();
  endtask

  task automatic push_n(int n, output logic [DW-1:0] sent[$]);
    sent = {};
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] v;
      v = rand_vec();
      fifo.push_back(v);
      sent.push_back(v);
    end
    drive_fifo();
  endtask

  task automatic pulse_start(logic [AW-1:0] base);
    start     = 1'b1;
    base_addr = base;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_ready(int r0, int budget, bit toggle);
    int n = 0;
    while (rdy_cyc.size() == r0 && n < budget) begin
      tick();
      if (toggle) begin
        gate = ~gate;
        drive_fifo();
      end
      n++;
    end
    chk("ready_timeout", rdy_cyc.size() > r0, 1);
    gate = 1'b1;
    drive_fifo();
    tick();
    tick();
  endtask

  task automatic wait_writes(int w0, int n, int budget);
    int k = 0;
    while (w_addr.size() - w0 < n && k < budget) begin
      tick();
      k++;
    end
    chk("writes_timeout", (w_addr.size() - w0) >= n, 1);
  endtask

  task automatic check_addrs(string name, int w0, logic [AW-1:0] base);
    int nw;
    nw = w_addr.size() - w0;
    chk({name, "_nwrites"}, nw, ROW);
    for (int i = 0; i < ((nw < ROW) ? nw : ROW); i++)
      chk({name, "_addr"}, w_addr[w0+i], AW'(base + AW'(i)));
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [DW-1:0] sent[$];
    logic [AW-1:0] wrap_exp[ROW];
    int w0, r0, p0, nw, r_before;

    wrap_exp = '{11'h7FE, 11'h7FF, 11'h000, 11'h001, 11'h002, 11'h003, 11'h004, 11'h005};

    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    gate      = 1'b0;
    drive_fifo();

    // Reset values.
    @(negedge clk);
    #1;
    chk("rst_cen",   sram_cen,   1);
    chk("rst_wen",   sram_wen,   1);
    chk("rst_addr",  sram_addr,  0);
    chk("rst_din",   sram_din,   0);
    chk("rst_busy",  busy,       0);
    chk("rst_ready", psum_ready, 0);
    chk("rst_err",   start_err,  0);
    chk("rst_rd",    ofifo_rd,   0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    // 1) Streaming: 8 back-to-back writes from 0x040.
    push_n(ROW, sent);
    gate = 1'b1;
    drive_fifo();
    w0 = w_addr.size();
    r0 = rdy_cyc.size();
    pulse_start(11'h040);
    wait_ready(r0, 40, 1'b0);
    check_addrs("t1", w0, 11'h040);
    nw = w_addr.size() - w0;
    if (nw >= ROW) begin
      for (int i = 0; i < ROW; i++) begin
        chk("t1_din", w_din[w0+i], sent[i]);
        chk("t1_consecutive", w_cyc[w0+i] - w_cyc[w0], i);
      end
      chk("t1_ready_lat", rdy_cyc[r0] - w_cyc[w0+ROW-1], 1);
    end
    chk("t1_nready", rdy_cyc.size() - r0, 1);
    $display("t1 streaming: %0d writes from base 040", nw);

    // 2) Bubbles: valid toggles every cycle.
    push_n(ROW, sent);
    gate = 1'b1;
    drive_fifo();
    w0 = w_addr.size();
    r0 = rdy_cyc.size();
    pulse_start(11'h200);
    wait_ready(r0, 60, 1'b1);
    check_addrs("t2", w0, 11'h200);
    chk("t2_nready", rdy_cyc.size() - r0, 1);
    $display("t2 bubbles: %0d writes from base 200", w_addr.size() - w0);

    // 3) Address wrap.
    push_n(ROW, sent);
    w0 = w_addr.size();
    r0 = rdy_cyc.size();
    pulse_start(11'h7FE);
    wait_ready(r0, 40, 1'b0);
    nw = w_addr.size() - w0;
    chk("t3_nwrites", nw, ROW);
    for (int i = 0; i < ((nw < ROW) ? nw : ROW); i++)
      chk("t3_wrap_addr", w_addr[w0+i], wrap_exp[i]);
    $display("t3 wrap: %0d writes from base 7fe", nw);

    // 4) Start while busy at vector 3.
    push_n(ROW, sent);
    w0 = w_addr.size();
    r0 = rdy_cyc.size();
    pulse_start(11'h300);
    wait_writes(w0, 3, 30);
    pulse_start(11'h555);
    wait_ready(r0, 40, 1'b0);
    chk("t4_start_err", start_err, 1);
    check_addrs("t4", w0, 11'h300);
    chk("t4_nready", rdy_cyc.size() - r0, 1);
    $display("t4 start while busy: start_err=%0b", start_err);

    // 5) Reset mid-tile after 4 writes, then a fresh tile at 0x100.
    push_n(ROW, sent);
    w0 = w_addr.size();
    r0 = rdy_cyc.size();
    pulse_start(11'h0A0);
    wait_writes(w0, 4, 30);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("t5_cen",   sram_cen,   1);
    chk("t5_wen",   sram_wen,   1);
    chk("t5_addr",  sram_addr,  0);
    chk("t5_din",   sram_din,   0);
    chk("t5_busy",  busy,       0);
    chk("t5_ready", psum_ready, 0);
    chk("t5_err",   start_err,  0);
    chk("t5_rd",    ofifo_rd,   0);
    fifo.delete();
    drive_fifo();
    r_before = rdy_cyc.size();
    tick();
    tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("t5_no_ready", rdy_cyc.size(), r_before);
    push_n(ROW, sent);
    w0 = w_addr.size();
    r0 = rdy_cyc.size();
    pulse_start(11'h100);
    wait_ready(r0, 40, 1'b0);
    check_addrs("t5", w0, 11'h100);
    $display("t5 reset mid-tile: restart wrote %0d vectors from base 100", w_addr.size() - w0);

    // 6) Surplus data: 10 vectors queued, exactly 8 popped.
    fifo.delete();
    push_n(ROW + 2, sent);
    p0 = n_pops;
    r0 = rdy_cyc.size();
    pulse_start(11'h010);
    wait_ready(r0, 40, 1'b0);
    chk("t6_pops",  n_pops - p0, ROW);
    chk("t6_left",  fifo.size(), 2);
    chk("t6_valid", ofifo_valid, 1);
    $display("t6 surplus: %0d pops, %0d vectors left", n_pops - p0, fifo.size());

    // 7) Randomized run.
    fifo.delete();
    drive_fifo();
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (reset) reset = 1'b0;
      if (fifo.size() < 12 && $urandom_range(0, 2) != 0) fifo.push_back(rand_vec());
      gate      = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 15) == 0);
      base_addr = AW'($urandom);
      drive_fifo();
      if ($urandom_range(0, 399) == 0) begin
        #2;
        reset = 1'b1;
      end
    end
    start = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    $display("t7 random: %0d writes, %0d tiles completed overall", w_addr.size(), rdy_cyc.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_psum_writeback
